// File: rtl/xe4_audio_sequencer_pkg.sv
// Shared definitions for the XE4 audio note sequencer: register map, note entry layout
// and engine state encoding.
package xe4_audio_sequencer_pkg;

    localparam int PERIOD_W   = 13;
    localparam int DURATION_W = 16;
    localparam int VOLUME_W   = 5;
    localparam int ENTRY_W    = PERIOD_W + DURATION_W + VOLUME_W;
    localparam int REMAIN_W   = 17;
    localparam int NUM_CH     = 3;

    localparam logic [15:0] AUDIO_BASE_DEFAULT = 16'h0110;

    localparam logic [3:0] REG_PERIOD_LO = 4'd0;
    localparam logic [3:0] REG_PERIOD_HI = 4'd1;
    localparam logic [3:0] REG_DUR_LO    = 4'd2;
    localparam logic [3:0] REG_DUR_HI    = 4'd3;
    localparam logic [3:0] REG_VOLUME    = 4'd4;
    localparam logic [3:0] REG_COMMIT    = 4'd5;
    localparam logic [3:0] REG_STATUS    = 4'd6;
    localparam logic [3:0] REG_FLUSH     = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2
    } engine_state_t;

    typedef struct packed {
        logic [PERIOD_W-1:0]   period;
        logic [DURATION_W-1:0] duration;
        logic [VOLUME_W-1:0]   volume;
    } note_entry_t;

    // Byte k of the five-register audio chip burst for one note.
    function automatic logic [7:0] entry_word(input note_entry_t e, input logic [2:0] k);
        logic [7:0] w;
        case (k)
            3'd0:    w = e.period[7:0];
            3'd1:    w = {3'b000, e.period[12:8]};
            3'd2:    w = e.duration[7:0];
            3'd3:    w = e.duration[15:8];
            3'd4:    w = {3'b000, e.volume};
            default: w = 8'h00;
        endcase
        return w;
    endfunction

    function automatic logic [1:0] next_channel(input logic [1:0] ch);
        return (ch == 2'd2) ? 2'd0 : ch + 2'd1;
    endfunction

endpackage

// File: rtl/xe4_note_fifo.sv
// Synchronous per-channel note FIFO; flush empties it in one cycle, a full FIFO
// refuses pushes even when popped in the same cycle.
module xe4_note_fifo
    import xe4_audio_sequencer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic               sysclk,
    input  logic               nreset,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [ENTRY_W-1:0] push_data,
    output logic [ENTRY_W-1:0] head,
    output logic               full,
    output logic               empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W:0]     count;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge sysclk) begin
        if (!nreset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end

    always_ff @(posedge sysclk) begin
        if (nreset && !flush && do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/xe4_audio_sequencer.sv
// Three-channel note sequencer: CPU stages notes into per-channel FIFOs and an engine
// replays each note as a five-register burst to the audio chip once its predecessor expires.
module xe4_audio_sequencer
    import xe4_audio_sequencer_pkg::*;
#(
    parameter logic [11:0] SEQ_MASK   = 12'h012,
    parameter logic [15:0] AUDIO_BASE = AUDIO_BASE_DEFAULT,
    parameter int          TICK_DIV   = 500000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        sysclk,
    input  logic        nreset,
    input  logic [15:0] Address,
    input  logic [7:0]  InData,
    input  logic        we,
    output logic [7:0]  OutData,
    output logic [15:0] AudAddress,
    output logic [7:0]  AudData,
    output logic        AudWe,
    output logic        Irq
);

    localparam logic [31:0] PRESC_RELOAD = 32'(TICK_DIV - 1);

    logic [3:0]            offset;
    logic                  sel;
    logic                  wr_en;
    logic                  commit_hit;
    logic                  flush_hit;
    logic [PERIOD_W-1:0]   stage_period;
    logic [DURATION_W-1:0] stage_duration;
    logic [VOLUME_W-1:0]   stage_volume;
    logic [ENTRY_W-1:0]    stage_entry;
    logic                  overflow;

    logic [NUM_CH-1:0]     push;
    logic [NUM_CH-1:0]     pop;
    logic [NUM_CH-1:0]     flush_ch;
    logic [NUM_CH-1:0]     fifo_full;
    logic [NUM_CH-1:0]     fifo_empty;
    logic [ENTRY_W-1:0]    head_raw [NUM_CH];
    note_entry_t           head_sel;

    logic [31:0]           presc;
    logic                  tick;
    logic [REMAIN_W-1:0]   remaining [NUM_CH];
    logic [NUM_CH-1:0]     zero_pending;
    logic [NUM_CH-1:0]     rem_zero;
    logic [NUM_CH-1:0]     ready;

    engine_state_t         state;
    logic [1:0]            cur_ch;
    logic [1:0]            rr_start;
    logic [2:0]            wr_idx;
    note_entry_t           cur_entry;
    logic                  busy;
    logic                  burst_end;
    logic                  found;
    logic [1:0]            pick;
    logic [1:0]            cand;
    logic [15:0]           chan_base;

    assign offset      = Address[3:0];
    assign sel         = (Address[15:4] == SEQ_MASK);
    assign wr_en       = we && sel;
    assign commit_hit  = wr_en && (offset == REG_COMMIT) && (InData[1:0] != 2'd3);
    assign flush_hit   = wr_en && (offset == REG_FLUSH);
    assign flush_ch    = flush_hit ? InData[NUM_CH-1:0] : '0;
    assign stage_entry = {stage_period, stage_duration, stage_volume};
    assign head_sel    = note_entry_t'(head_raw[cur_ch]);
    assign busy        = (state != ST_IDLE);
    assign burst_end   = (state == ST_WRITE) && (wr_idx == 3'd5);
    assign tick        = (presc == '0);
    assign chan_base   = AUDIO_BASE + 16'(cur_ch) * 16'd5;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign push[i]     = commit_hit && (InData[1:0] == 2'(i));
        assign pop[i]      = (state == ST_LOAD) && (cur_ch == 2'(i));
        assign rem_zero[i] = (remaining[i] == '0);
        assign ready[i]    = rem_zero[i] && !fifo_empty[i] && !(busy && cur_ch == 2'(i));

        xe4_note_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .sysclk    (sysclk),
            .nreset    (nreset),
            .push      (push[i]),
            .pop       (pop[i]),
            .flush     (flush_ch[i]),
            .push_data (stage_entry),
            .head      (head_raw[i]),
            .full      (fifo_full[i]),
            .empty     (fifo_empty[i])
        );
    end

    // Round-robin search starting at the channel after the one serviced last.
    always_comb begin
        found = 1'b0;
        pick  = 2'd0;
        cand  = rr_start;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found && ready[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
            cand = next_channel(cand);
        end
    end

    always_ff @(posedge sysclk) begin
        if (!nreset) begin
            stage_period   <= '0;
            stage_duration <= '0;
            stage_volume   <= '0;
        end else if (wr_en) begin
            case (offset)
                REG_PERIOD_LO: stage_period[7:0]    <= InData;
                REG_PERIOD_HI: stage_period[12:8]   <= InData[4:0];
                REG_DUR_LO:    stage_duration[7:0]  <= InData;
                REG_DUR_HI:    stage_duration[15:8] <= InData;
                REG_VOLUME:    stage_volume         <= InData[4:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge sysclk) begin
        if (!nreset) begin
            overflow <= 1'b0;
        end else if (flush_hit) begin
            overflow <= 1'b0;
        end else if (commit_hit && fifo_full[InData[1:0]]) begin
            overflow <= 1'b1;
        end
    end

    always_ff @(posedge sysclk) begin
        if (!nreset) begin
            OutData <= 8'h00;
        end else if (sel) begin
            case (offset)
                REG_PERIOD_LO: OutData <= stage_period[7:0];
                REG_PERIOD_HI: OutData <= {3'b000, stage_period[12:8]};
                REG_DUR_LO:    OutData <= stage_duration[7:0];
                REG_DUR_HI:    OutData <= stage_duration[15:8];
                REG_VOLUME:    OutData <= {3'b000, stage_volume};
                REG_STATUS:    OutData <= {busy, overflow, fifo_full, fifo_empty};
                default:       OutData <= 8'h00;
            endcase
        end else begin
            OutData <= 8'h00;
        end
    end

    always_ff @(posedge sysclk) begin
        if (!nreset || tick) presc <= PRESC_RELOAD;
        else                 presc <= presc - 32'd1;
    end

    // A flush of the channel in service is deferred until its burst completes.
    always_ff @(posedge sysclk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (!nreset) begin
                remaining[c]    <= '0;
                zero_pending[c] <= 1'b0;
            end else begin
                if (burst_end && cur_ch == 2'(c))
                    zero_pending[c] <= 1'b0;
                else if (flush_ch[c] && busy && cur_ch == 2'(c))
                    zero_pending[c] <= 1'b1;

                if (state == ST_LOAD && cur_ch == 2'(c))
                    remaining[c] <= REMAIN_W'(head_sel.duration) + 17'd1;
                else if (burst_end && cur_ch == 2'(c) && (zero_pending[c] || flush_ch[c]))
                    remaining[c] <= '0;
                else if (flush_ch[c] && !(busy && cur_ch == 2'(c)))
                    remaining[c] <= '0;
                else if (tick && !rem_zero[c])
                    remaining[c] <= remaining[c] - 17'd1;
            end
        end
    end

    always_ff @(posedge sysclk) begin
        if (!nreset) Irq <= 1'b0;
        else         Irq <= |(fifo_empty & rem_zero);
    end

    // Engine: LOAD emits burst word 0 from the FIFO head, WRITE emits words 1-4.
    always_ff @(posedge sysclk) begin
        if (!nreset) begin
            state      <= ST_IDLE;
            cur_ch     <= 2'd0;
            rr_start   <= 2'd0;
            wr_idx     <= 3'd0;
            cur_entry  <= '0;
            AudWe      <= 1'b0;
            AudAddress <= 16'h0000;
            AudData    <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        cur_ch <= pick;
                        state  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    cur_entry  <= head_sel;
                    AudWe      <= 1'b1;
                    AudAddress <= chan_base;
                    AudData    <= entry_word(head_sel, 3'd0);
                    wr_idx     <= 3'd1;
                    rr_start   <= next_channel(cur_ch);
                    state      <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (wr_idx == 3'd5) begin
                        AudWe <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        AudAddress <= chan_base + 16'(wr_idx);
                        AudData    <= entry_word(cur_entry, wr_idx);
                        wr_idx     <= wr_idx + 3'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xe4_audio_sequencer.sv
// Directed self-checking bench for xe4_audio_sequencer: register access, bursts,
// round-robin order, FIFO overflow/flush, tick timing and reset mid-burst.
module tb_xe4_audio_sequencer;

    localparam logic [11:0] SEQ_MASK = 12'h012;

    logic        sysclk = 1'b0;
    logic        nreset;
    logic [15:0] Address;
    logic [7:0]  InData;
    logic        we;
    logic [7:0]  OutData;
    logic [15:0] AudAddress;
    logic [7:0]  AudData;
    logic        AudWe;
    logic        Irq;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rel = 0;
    int last_wr_cyc = 0;

    int          log_cyc  [$];
    logic [15:0] log_addr [$];
    logic [7:0]  log_data [$];

    xe4_audio_sequencer #(
        .SEQ_MASK   (12'h012),
        .AUDIO_BASE (16'h0110),
        .TICK_DIV   (10),
        .FIFO_DEPTH (8)
    ) dut (
        .sysclk     (sysclk),
        .nreset     (nreset),
        .Address    (Address),
        .InData     (InData),
        .we         (we),
        .OutData    (OutData),
        .AudAddress (AudAddress),
        .AudData    (AudData),
        .AudWe      (AudWe),
        .Irq        (Irq)
    );

    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) cyc <= cyc + 1;

    always @(negedge sysclk) begin
        if (AudWe === 1'b1) begin
            log_cyc.push_back(cyc);
            log_addr.push_back(AudAddress);
            log_data.push_back(AudData);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] off, input logic [7:0] data);
        Address     = {SEQ_MASK, off};
        InData      = data;
        we          = 1'b1;
        last_wr_cyc = cyc;
        @(negedge sysclk);
        we = 1'b0;
    endtask

    task automatic readReg(input logic [3:0] off, input logic [7:0] expected, input string tag);
        Address = {SEQ_MASK, off};
        we      = 1'b0;
        @(negedge sysclk);
        checkOutput(tag, 32'(OutData), 32'(expected));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic clearLog();
        log_cyc.delete();
        log_addr.delete();
        log_data.delete();
    endtask

    task automatic waitLog(input int n, input int budget, input string tag);
        int waited = 0;
        while (log_addr.size() < n && waited < budget) begin
            @(negedge sysclk);
            waited++;
        end
        checkOutput(tag, 32'(log_addr.size()), 32'(n));
    endtask

    // bytes holds the five expected burst bytes, word 0 in the top byte.
    task automatic checkBurst(input int first, input logic [15:0] base, input logic [39:0] bytes, input string tag);
        for (int k = 0; k < 5; k++) begin
            if (first + k < log_addr.size()) begin
                checkOutput($sformatf("%s_addr%0d", tag, k), 32'(log_addr[first+k]), 32'(base + 16'(k)));
                checkOutput($sformatf("%s_data%0d", tag, k), 32'(log_data[first+k]), 32'(bytes[39-8*k -: 8]));
                checkOutput($sformatf("%s_cyc%0d", tag, k), 32'(log_cyc[first+k] - log_cyc[first]), 32'(k));
            end else begin
                checkOutput($sformatf("%s_count", tag), 32'(log_addr.size()), 32'(first + k + 1));
            end
        end
    endtask

    initial begin
        int c0, c1, c2, t, ticks;

        nreset  = 1'b0;
        Address = 16'h0000;
        InData  = 8'h00;
        we      = 1'b0;
        idle(3);
        checkOutput("reset_audwe", 32'(AudWe), 32'h0);
        checkOutput("reset_audaddr", 32'(AudAddress), 32'h0);
        checkOutput("reset_auddata", 32'(AudData), 32'h0);
        checkOutput("reset_outdata", 32'(OutData), 32'h0);
        checkOutput("reset_irq", 32'(Irq), 32'h0);

        rel    = cyc;
        nreset = 1'b1;
        @(negedge sysclk);
        checkOutput("irq_all_empty", 32'(Irq), 32'h1);
        readReg(4'd6, 8'h07, "status_after_reset");

        applyStimulus(4'd1, 8'hFF);
        readReg(4'd1, 8'h1F, "period_msb_mask");
        applyStimulus(4'd8, 8'h55);
        readReg(4'd8, 8'h00, "offset8_reads_zero");
        Address = 16'h0000;
        we      = 1'b0;
        @(negedge sysclk);
        checkOutput("outside_window_zero", 32'(OutData), 32'h0);

        applyStimulus(4'd5, 8'h03);
        idle(5);
        readReg(4'd6, 8'h07, "commit_ch3_ignored");
        checkOutput("commit_ch3_no_write", 32'(log_addr.size()), 32'h0);

        // Single note on ch0.
        clearLog();
        applyStimulus(4'd0, 8'h23);
        applyStimulus(4'd1, 8'h01);
        applyStimulus(4'd2, 8'h02);
        applyStimulus(4'd3, 8'h00);
        applyStimulus(4'd4, 8'h1F);
        readReg(4'd4, 8'h1F, "volume_readback");
        applyStimulus(4'd5, 8'h00);
        c0 = last_wr_cyc;
        waitLog(5, 20, "single_count");
        if (log_cyc.size() >= 5)
            checkOutput("single_latency", 32'(log_cyc[0] - c0), 32'd3);
        checkBurst(0, 16'h0110, 40'h23_01_02_00_1F, "single");
        idle(50);

        // Three channels committed in one idle window.
        clearLog();
        applyStimulus(4'd5, 8'h00);
        c0 = last_wr_cyc;
        applyStimulus(4'd4, 8'h05);
        applyStimulus(4'd5, 8'h01);
        applyStimulus(4'd2, 8'hFF);
        applyStimulus(4'd3, 8'hFF);
        applyStimulus(4'd4, 8'h0A);
        applyStimulus(4'd5, 8'h02);
        waitLog(15, 60, "rr_count");
        if (log_cyc.size() >= 15) begin
            checkOutput("rr_ch0_start", 32'(log_cyc[0] - c0), 32'd3);
            checkOutput("rr_ch1_start", 32'(log_cyc[5] - c0), 32'd10);
            checkOutput("rr_ch2_start", 32'(log_cyc[10] - c0), 32'd17);
        end
        checkBurst(0, 16'h0110, 40'h23_01_02_00_1F, "rr_ch0");
        checkBurst(5, 16'h0115, 40'h23_01_02_00_05, "rr_ch1");
        checkBurst(10, 16'h011A, 40'h23_01_FF_FF_0A, "rr_ch2");
        idle(5);

        // Overflow ch2, whose long note keeps it from draining.
        for (int i = 0; i < 9; i++) applyStimulus(4'd5, 8'h02);
        readReg(4'd6, 8'h63, "status_full_overflow");
        applyStimulus(4'd7, 8'h04);
        readReg(4'd6, 8'h07, "status_after_flush");
        @(negedge sysclk);
        checkOutput("irq_after_flush", 32'(Irq), 32'h1);
        idle(40);

        // Two ch0 notes: the second follows three ticks after the first LOAD.
        clearLog();
        applyStimulus(4'd2, 8'h02);
        applyStimulus(4'd3, 8'h00);
        applyStimulus(4'd4, 8'h11);
        applyStimulus(4'd5, 8'h00);
        c1 = last_wr_cyc;
        applyStimulus(4'd5, 8'h00);
        waitLog(10, 120, "tick_count");
        if (log_cyc.size() >= 10) begin
            checkOutput("tick_first_latency", 32'(log_cyc[0] - c1), 32'd3);
            t     = log_cyc[0] - 1;
            ticks = 0;
            while (ticks < 3) begin
                t++;
                if ((t - rel) % 10 == 9) ticks++;
            end
            checkOutput("tick_second_issue", 32'(log_cyc[5]), 32'(t + 3));
        end
        checkBurst(5, 16'h0110, 40'h23_01_02_00_11, "tick_second");
        idle(40);

        // Reset during the third write of a ch1 burst.
        clearLog();
        applyStimulus(4'd5, 8'h01);
        c2 = last_wr_cyc;
        idle(4);
        checkOutput("pre_reset_audwe", 32'(AudWe), 32'h1);
        nreset = 1'b0;
        @(negedge sysclk);
        checkOutput("midreset_audwe", 32'(AudWe), 32'h0);
        checkOutput("midreset_audaddr", 32'(AudAddress), 32'h0);
        checkOutput("midreset_auddata", 32'(AudData), 32'h0);
        checkOutput("midreset_outdata", 32'(OutData), 32'h0);
        checkOutput("midreset_irq", 32'(Irq), 32'h0);
        checkOutput("midreset_writes", 32'(log_addr.size()), 32'd3);
        if (log_addr.size() >= 3) begin
            checkOutput("midreset_first_cyc", 32'(log_cyc[0] - c2), 32'd3);
            checkOutput("midreset_last_addr", 32'(log_addr[2]), 32'h0117);
            checkOutput("midreset_last_data", 32'(log_data[2]), 32'h02);
        end
        rel    = cyc;
        nreset = 1'b1;
        idle(10);
        checkOutput("postreset_no_writes", 32'(log_addr.size()), 32'd3);
        readReg(4'd6, 8'h07, "postreset_status");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/xe4_audio_sequencer.md
XE4_AUDIO_SEQUENCER -- requirements
Module: xe4_audio_sequencer

Interface
REQ-001 Parameter SEQ_MASK, default 12'h012: CPU register window, selected when Address[15:4]==SEQ_MASK.
REQ-002 Parameter AUDIO_BASE, default 16'h0110: base address of the downstream audio chip registers.
REQ-003 Parameter TICK_DIV, default 500000: sysclk cycles per 10 ms sequencer tick at 50 MHz.
REQ-004 Parameter FIFO_DEPTH, default 8: note entries per channel, power of two.
REQ-005 sysclk  in  1  sole clock; all logic on its rising edge.
REQ-006 nreset  in  1  synchronous, active-low reset.
REQ-007 Address  in  16  CPU bus address.
REQ-008 InData  in  8  CPU write data.
REQ-009 we  in  1  CPU write strobe, one write per cycle.
REQ-010 OutData  out  8  CPU read data, registered.
REQ-011 AudAddress  out  16  audio chip register address.
REQ-012 AudData  out  8  audio chip write data.
REQ-013 AudWe  out  1  audio chip write strobe.
REQ-014 Irq  out  1  high while any channel FIFO is empty and idle.

Function
REQ-015 CPU registers (offset Address[3:0]): 0 period LSB, 1 period MSB[4:0], 2 duration LSB, 3 duration MSB, 4 volume[4:0], 5 commit, 6 status, 7 flush; offsets 8-15 ignored on write and read 8'h00.
REQ-016 Writes to offsets 0-4 update staging registers only; reads return the staging value, upper unused bits 0.
REQ-017 Commit write with InData[1:0]=c (0..2) pushes the staging entry {period13, duration16, volume5} into FIFO c; c=3 ignored.
REQ-018 Push to a full FIFO is dropped and sets sticky Overflow.
REQ-019 Status read: [2:0] empty flags ch0-2, [5:3] full flags, [6] Overflow, [7] engine busy.
REQ-020 Flush write: InData[i]=1 empties FIFO i and zeroes its remaining-ticks counter; any flush write clears Overflow.
REQ-021 Tick prescaler counts TICK_DIV-1 down to 0; tick pulse one cycle at 0, then reload.
REQ-022 Per channel 17-bit remaining-ticks counter decrements on tick when nonzero, saturating at 0.
REQ-023 Channel ready: remaining==0, FIFO non-empty, not being serviced.
REQ-024 Engine FSM states IDLE, LOAD, WRITE; IDLE->LOAD when any channel ready, round-robin from channel after last serviced (ch0 first after reset).
REQ-025 LOAD (1 cycle): pop head entry, latch it, set remaining = duration+1.
REQ-026 WRITE (5 cycles, k=0..4): AudWe=1, AudAddress=AUDIO_BASE+5*ch+k, AudData = period LSB, {3'b0,period[12:8]}, duration LSB, duration MSB, {3'b0,volume}; then IDLE.
REQ-027 AudWe is 0 outside WRITE; AudAddress/AudData hold last value.
REQ-028 Latency: ready seen in IDLE -> first AudWe exactly 2 cycles later.
REQ-029 Push and pop on same FIFO in same cycle both take effect; count unchanged; full FIFO accepts no push even if popped.
REQ-030 Flush of the channel currently in WRITE does not abort the 5-write burst; remaining is forced to 0 after it ends.
REQ-031 Tick coincident with LOAD of that channel: LOAD value wins.
REQ-032 Irq = OR over channels of (empty AND remaining==0), registered.

Reset
REQ-033 On nreset=0 at a clock edge: FIFOs empty, pointers 0, remaining 0, staging 0, Overflow 0, prescaler TICK_DIV-1, FSM IDLE, round-robin to ch0, OutData 8'h00, AudAddress 16'h0000, AudData 8'h00, AudWe 0, Irq 0.
REQ-034 Reset mid-WRITE terminates the burst immediately; no further AudWe.

Structure
REQ-035 Shared package holds the register offsets, FSM state encoding, entry field widths and AUDIO_BASE default.
REQ-036 One sub-module xe4_note_fifo (synchronous FIFO, 34-bit entries, push/pop/flush, full/empty), instantiated three times.

Verification
REQ-037 Stage period 0x0123, duration 0x0002, volume 0x1F, commit ch0 -> within 2 cycles AudWe writes 0x23,0x01,0x02,0x00,0x1F to 0x0110-0x0114.
REQ-038 Commit entries to ch0, ch1 and ch2 in one idle window -> bursts serviced in order ch0, ch1, ch2, no overlap.
REQ-039 Push 9 entries to ch2 (depth 8) -> status reads full[5]=1, Overflow[6]=1; flush 0x04 -> status 0x04-style empty flag set, Overflow 0.
REQ-040 Duration 0x0002, TICK_DIV=10 -> next ch0 entry issued exactly 3 ticks after the first LOAD.
REQ-041 Assert nreset during 3rd WRITE cycle -> AudWe 0 next cycle, all outputs at reset values, Irq 0.
